// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the default bus timeout.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int unsigned LSU_TIMEOUT_DEF = 255;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables and replication, load lane
// extraction with sign/zero extension, and the alignment check.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_unsigned,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_offset)
      2'd0:    w_byte = i_mem_rdata[7:0];
      2'd1:    w_byte = i_mem_rdata[15:8];
      2'd2:    w_byte = i_mem_rdata[23:16];
      default: w_byte = i_mem_rdata[31:24];
    endcase
    w_half = i_offset[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
  end

  always_comb begin
    o_be       = '0;
    o_wdata    = i_wdata;
    o_rdata    = i_mem_rdata;
    o_misalign = 1'b0;
    case (i_size)
      SZ_BYTE: begin
        o_be    = 4'b0001 << i_offset;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        o_be       = 4'b0011 << i_offset;
        o_wdata    = {2{i_wdata[15:0]}};
        o_rdata    = {{16{~i_unsigned & w_half[15]}}, w_half};
        o_misalign = i_offset[0];
      end
      SZ_WORD: begin
        o_be       = 4'b1111;
        o_misalign = |i_offset;
      end
      default: o_misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store unit: one req/gnt/rvalid bus transaction per load/store,
// stalling the core until completion and flagging illegal or timed-out accesses.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = LSU_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned   CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [3:0]        r_mem_be;
  logic [31:0]       r_mem_wdata;
  logic [1:0]        r_off;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [31:0]       r_rdata;

  logic              w_idle;
  logic [1:0]        w_size;
  logic [1:0]        w_off;
  logic              w_uns;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_load;
  logic              w_misalign;

  // One aligner serves both phases: live request fields while idle,
  // latched fields while the response is outstanding.
  assign w_idle = (r_state == ST_IDLE);
  assign w_size = w_idle ? req_size     : r_size;
  assign w_off  = w_idle ? addr[1:0]    : r_off;
  assign w_uns  = w_idle ? req_unsigned : r_unsigned;

  lsu_align u_align (
    .i_size      (w_size),
    .i_offset    (w_off),
    .i_wdata     (wdata),
    .i_mem_rdata (mem_rdata),
    .i_unsigned  (w_uns),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .o_rdata     (w_load),
    .o_misalign  (w_misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
      r_off       <= '0;
      r_size      <= '0;
      r_unsigned  <= 1'b0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_err <= 1'b0;
          if (req_valid) begin
            if (w_misalign) begin
              r_err   <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= req_we;
              r_mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
              r_mem_be    <= w_be;
              r_mem_wdata <= w_wdata;
              r_off       <= addr[1:0];
              r_size      <= req_size;
              r_unsigned  <= req_unsigned;
              r_cnt       <= '0;
              r_state     <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            r_mem_req <= 1'b0;
            r_cnt     <= '0;
            r_state   <= r_mem_we ? ST_DONE : ST_WAIT;
          end else if (r_cnt == CNT_LAST) begin
            r_mem_req <= 1'b0;
            r_err     <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            r_rdata <= w_load;
            r_state <= ST_DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_err   <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_err   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Gating with rst_n keeps stall low while reset is held even if the
  // core still presents req_valid.
  assign stall     = rst_n & req_valid & (r_state != ST_DONE);
  assign done      = (r_state == ST_DONE);
  assign err       = r_err;
  assign rdata     = r_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_be    = r_mem_be;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: directed vector table, reset-abort sequences and
// randomized accesses checked against an arithmetic reference model.
module tb_lsu_mem_stage;

  localparam int unsigned TMO = 4;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdmem;
    int          gdly;
    int          rdly;
    bit          noise;
  } txn_t;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rdata;
    int          nreq;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwd;
  } exp_t;

  typedef struct {
    txn_t t;
    exp_t e;
  } vec_t;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rdata;
    int          nreq;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic        mwe;
    bit          stall_bad;
    bit          err_bad;
    logic        done_after;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] addr, wdata;
  logic        stall, done, err;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int n_vec = 0;
  int n_bad = 0;

  lsu_mem_stage #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .done(done), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic txn_t mk_txn(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] rm, input int g, input int r);
    txn_t t;
    t.we = we; t.size = size; t.uns = uns; t.addr = a; t.wdata = wd;
    t.rdmem = rm; t.gdly = g; t.rdly = r; t.noise = 1'b0;
    return t;
  endfunction

  function automatic exp_t mk_exp(input int cyc, input logic e_err, input logic [31:0] rd,
                                  input int nreq, input logic [3:0] be,
                                  input logic [31:0] ma, input logic [31:0] mwd);
    exp_t e;
    e.cyc = cyc; e.err = e_err; e.rdata = rd; e.nreq = nreq;
    e.be = be; e.maddr = ma; e.mwd = mwd;
    return e;
  endfunction

  // Reference model: cycle counts from req_valid (index 0) to the done cycle,
  // plus lane/extension results derived arithmetically.
  function automatic exp_t model(input txn_t t, input logic [31:0] prev);
    exp_t        e;
    logic [1:0]  off;
    logic [31:0] lane, v;
    bit          bad;
    off     = t.addr[1:0];
    e.rdata = prev;
    e.err   = 1'b0;
    e.maddr = t.addr & 32'hFFFF_FFFC;
    e.be    = '0;
    e.mwd   = t.wdata;
    bad = (t.size == 2'd3) || (t.size == 2'd1 && off[0]) || (t.size == 2'd2 && off != 2'd0);
    if (t.size == 2'd0) begin
      e.be  = 4'(32'd1 << off);
      e.mwd = 32'(t.wdata[7:0]) * 32'h0101_0101;
    end else if (t.size == 2'd1) begin
      e.be  = 4'(32'd3 << off);
      e.mwd = 32'(t.wdata[15:0]) * 32'h0001_0001;
    end else begin
      e.be = 4'hF;
    end
    if (bad) begin
      e.err = 1'b1; e.cyc = 1; e.nreq = 0;
    end else if (t.gdly >= int'(TMO)) begin
      e.err = 1'b1; e.cyc = 1 + int'(TMO); e.nreq = int'(TMO);
    end else begin
      e.nreq = t.gdly + 1;
      if (t.we) begin
        e.cyc = 2 + t.gdly;
      end else if (t.rdly >= int'(TMO)) begin
        e.err = 1'b1; e.cyc = 2 + t.gdly + int'(TMO);
      end else begin
        e.cyc = 3 + t.gdly + t.rdly;
        lane  = t.rdmem >> (8 * off);
        if (t.size == 2'd0) begin
          v = lane % 256;
          if (!t.uns && v >= 128) v = v - 256;
        end else if (t.size == 2'd1) begin
          v = lane % 65536;
          if (!t.uns && v >= 32768) v = v - 65536;
        end else begin
          v = t.rdmem;
        end
        e.rdata = v;
      end
    end
    return e;
  endfunction

  // Called on a negedge with the DUT idle; acts as core and memory, returns
  // one negedge after the done pulse with req_valid dropped.
  task automatic run_access(input txn_t t, output obs_t o);
    int cyc = 0, nreq = 0, wcnt = 0;
    bit granted = 0, fin = 0;
    o = '{default: '0};
    o.cyc = 999;
    req_valid = 1'b1; req_we = t.we; req_size = t.size; req_unsigned = t.uns;
    addr = t.addr; wdata = t.wdata;
    mem_gnt = 1'b0; mem_rvalid = t.noise; mem_rdata = t.noise ? 32'hBAD0_BAD0 : '0;
    while (!fin && cyc < 64) begin
      @(negedge clk);
      cyc++;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (done) begin
        fin = 1; o.cyc = cyc; o.err = err; o.rdata = rdata;
        if (stall) o.stall_bad = 1;
      end else begin
        if (!stall) o.stall_bad = 1;
        if (err) o.err_bad = 1;
        if (mem_req) begin
          if (nreq == 0) begin
            o.be = mem_be; o.maddr = mem_addr; o.mwd = mem_wdata; o.mwe = mem_we;
          end
          if (nreq == t.gdly) begin
            mem_gnt = 1'b1; granted = 1;
          end else if (t.noise) begin
            mem_rvalid = 1'b1; mem_rdata = ~t.rdmem;
          end
          nreq++;
        end else if (granted && !t.we) begin
          if (wcnt == t.rdly) begin
            mem_rvalid = 1'b1; mem_rdata = t.rdmem;
          end
          wcnt++;
        end
      end
    end
    o.nreq = nreq;
    req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    o.done_after = done;
  endtask

  task automatic compare(input string nm, input txn_t t, input obs_t o, input exp_t e);
    chk({nm, ".cyc"},   32'(o.cyc),  32'(e.cyc));
    chk({nm, ".err"},   32'(o.err),  32'(e.err));
    chk({nm, ".rdata"}, o.rdata,     e.rdata);
    chk({nm, ".nreq"},  32'(o.nreq), 32'(e.nreq));
    chk({nm, ".stall"}, 32'(o.stall_bad), 32'd0);
    chk({nm, ".errlo"}, 32'(o.err_bad),   32'd0);
    chk({nm, ".pulse"}, 32'(o.done_after), 32'd0);
    if (e.nreq > 0) begin
      chk({nm, ".be"},    32'(o.be),  32'(e.be));
      chk({nm, ".maddr"}, o.maddr,    e.maddr);
      chk({nm, ".mwd"},   o.mwd,      e.mwd);
      chk({nm, ".mwe"},   32'(o.mwe), 32'(t.we));
    end
  endtask

  vec_t tbl[$];

  task automatic add_vec(input txn_t t, input exp_t e);
    vec_t v;
    v.t = t; v.e = e;
    tbl.push_back(v);
  endtask

  initial begin
    obs_t        o;
    txn_t        t;
    exp_t        e;
    logic [31:0] cur_rdata;
    int          r;

    add_vec(mk_txn(1, 2, 0, 32'h100, 32'hDEADBEEF, 0, 1, 0), mk_exp(3, 0, 32'h0,        2, 4'hF, 32'h100, 32'hDEADBEEF));
    add_vec(mk_txn(0, 0, 0, 32'h203, 0, 32'h80112233, 0, 0), mk_exp(3, 0, 32'hFFFFFF80, 1, 4'h8, 32'h200, 32'h0));
    add_vec(mk_txn(0, 0, 1, 32'h203, 0, 32'h80112233, 0, 0), mk_exp(3, 0, 32'h00000080, 1, 4'h8, 32'h200, 32'h0));
    add_vec(mk_txn(0, 1, 0, 32'h202, 0, 32'h8001ABCD, 0, 0), mk_exp(3, 0, 32'hFFFF8001, 1, 4'hC, 32'h200, 32'h0));
    add_vec(mk_txn(1, 1, 0, 32'h202, 32'h1234, 0, 0, 0),     mk_exp(2, 0, 32'hFFFF8001, 1, 4'hC, 32'h200, 32'h12341234));
    add_vec(mk_txn(0, 2, 0, 32'h102, 0, 0, 0, 0),            mk_exp(1, 1, 32'hFFFF8001, 0, 4'h0, 32'h0,   32'h0));
    add_vec(mk_txn(0, 3, 0, 32'h100, 0, 0, 0, 0),            mk_exp(1, 1, 32'hFFFF8001, 0, 4'h0, 32'h0,   32'h0));
    add_vec(mk_txn(0, 1, 1, 32'h200, 0, 32'h8001ABCD, 0, 0), mk_exp(3, 0, 32'h0000ABCD, 1, 4'h3, 32'h200, 32'h0));
    add_vec(mk_txn(0, 0, 0, 32'h201, 0, 32'h12345678, 0, 0), mk_exp(3, 0, 32'h00000056, 1, 4'h2, 32'h200, 32'h0));
    add_vec(mk_txn(1, 0, 0, 32'h101, 32'hA5, 0, 0, 0),       mk_exp(2, 0, 32'h00000056, 1, 4'h2, 32'h100, 32'hA5A5A5A5));
    add_vec(mk_txn(1, 2, 0, 32'h400, 32'h11111111, 0, 9, 0), mk_exp(5, 1, 32'h00000056, 4, 4'hF, 32'h400, 32'h11111111));
    add_vec(mk_txn(0, 2, 0, 32'h300, 0, 32'hCAFEF00D, 2, 1), mk_exp(6, 0, 32'hCAFEF00D, 3, 4'hF, 32'h300, 32'h0));
    add_vec(mk_txn(0, 2, 0, 32'h304, 0, 32'h12121212, 0, 9), mk_exp(6, 1, 32'hCAFEF00D, 1, 4'hF, 32'h304, 32'h0));
    add_vec(mk_txn(0, 1, 0, 32'h201, 0, 0, 0, 0),            mk_exp(1, 1, 32'hCAFEF00D, 0, 4'h0, 32'h0,   32'h0));

    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    addr = 32'h100; wdata = 32'h5555_5555;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    chk("rst_ctl",   32'({mem_req, mem_we, done, err, stall, mem_be}), 32'd0);
    chk("rst_addr",  mem_addr,  32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", rdata,     32'd0);
    req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      run_access(tbl[i].t, o);
      compare($sformatf("tbl%0d", i), tbl[i].t, o, tbl[i].e);
    end

    // Reset while the request is on the bus: mem_req must fall at once.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; addr = 32'h500;
    @(negedge clk);
    chk("rstreq_pre", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstreq_mreq",  32'(mem_req), 32'd0);
    chk("rstreq_stall", 32'(stall),   32'd0);
    chk("rstreq_done",  32'(done),    32'd0);
    @(negedge clk);
    chk("rstreq_nodone", 32'(done), 32'd0);
    rst_n = 1'b1;
    t = mk_txn(0, 2, 0, 32'h600, 0, 32'h600D600D, 1, 1);
    t.noise = 1'b1;
    e = model(t, 32'h0);
    run_access(t, o);
    compare("rstreq_fresh", t, o, e);

    // Reset while waiting for read data; the aborted load's rvalid arrives late.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; addr = 32'h700;
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("rstwait_stall_pre", 32'(stall), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstwait_mreq",  32'(mem_req), 32'd0);
    chk("rstwait_stall", 32'(stall),   32'd0);
    chk("rstwait_done",  32'(done),    32'd0);
    @(negedge clk);
    chk("rstwait_nodone", 32'(done), 32'd0);
    rst_n = 1'b1;
    t = mk_txn(1, 0, 0, 32'h703, 32'h3C, 0, 0, 0);
    t.noise = 1'b1;
    e = model(t, 32'h0);
    run_access(t, o);
    compare("rstwait_fresh", t, o, e);
    cur_rdata = e.rdata;

    for (int k = 0; k < 200; k++) begin
      r       = $urandom_range(0, 9);
      t.size  = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      t.we    = 1'($urandom_range(0, 1));
      t.uns   = 1'($urandom_range(0, 1));
      t.addr  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (t.size == 2'd1) t.addr = t.addr & 32'hFFFF_FFFE;
        if (t.size == 2'd2) t.addr = t.addr & 32'hFFFF_FFFC;
      end
      t.wdata = $urandom;
      t.rdmem = $urandom;
      t.gdly  = $urandom_range(0, 5);
      t.rdly  = $urandom_range(0, 5);
      t.noise = 1'($urandom_range(0, 1));
      e = model(t, cur_rdata);
      run_access(t, o);
      compare($sformatf("rnd%0d", k), t, o, e);
      cur_rdata = e.rdata;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
